// File: rtl/udp_oe_pkg.sv
// Shared UDP offload-engine constants and types for the TX channel arbiter.
package udp_oe_pkg;

  localparam int unsigned IO_PIPES_NUM_CHAN   = 2;
  localparam int unsigned TXARB_STALL_TIMEOUT = 1024;
  localparam int unsigned TXARB_CNT_W         = 32;
  localparam int unsigned TXARB_ABORT_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT,
    DRAIN
  } txarb_state_e;

endpackage

// File: rtl/udp_oe_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, circular.
module udp_oe_rr_pick
  import udp_oe_pkg::*;
#(
  parameter int unsigned NUM_CHAN = IO_PIPES_NUM_CHAN,
  parameter int unsigned IW       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [IW-1:0]       gnt_idx,
  output logic                gnt_vld
);

  // Wrap by compare rather than modulo so a non-power-of-2 NUM_CHAN works.
  always_comb begin
    int unsigned c;
    logic        hit;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    c       = 0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      c = 32'(ptr) + i;
      if (c >= NUM_CHAN) c = c - NUM_CHAN;
      hit = 1'b0;
      for (int unsigned j = 0; j < NUM_CHAN; j++) begin
        if (j == c) hit = req[j];
      end
      if (!gnt_vld && hit) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/udp_oe_tx_chan_arbiter.sv
// Packet-atomic round-robin arbiter muxing NUM_CHAN packetiser streams onto the
// single MAC TX stream, with a stall watchdog that aborts dead sources.
module udp_oe_tx_chan_arbiter
  import udp_oe_pkg::*;
#(
  parameter int unsigned NUM_CHAN      = IO_PIPES_NUM_CHAN,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned STALL_TIMEOUT = TXARB_STALL_TIMEOUT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CHAN-1:0]                   chan_en,
  input  logic [NUM_CHAN-1:0]                   in_tvalid,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0]        in_tdata,
  input  logic [NUM_CHAN*(DATA_WIDTH/8)-1:0]    in_tkeep,
  input  logic [NUM_CHAN-1:0]                   in_tlast,
  output logic [NUM_CHAN-1:0]                   in_tready,
  output logic                                  out_tvalid,
  output logic [DATA_WIDTH-1:0]                 out_tdata,
  output logic [DATA_WIDTH/8-1:0]               out_tkeep,
  output logic                                  out_tlast,
  output logic                                  out_tuser,
  input  logic                                  out_tready,
  output logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] cur_grant,
  output logic                                  busy,
  output logic [NUM_CHAN*TXARB_CNT_W-1:0]       pkt_cnt,
  output logic [NUM_CHAN*TXARB_ABORT_CNT_W-1:0] abort_cnt
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned IW     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int unsigned WD_W   = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam bit          WD_EN  = (STALL_TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

  txarb_state_e                 state_q;
  logic [IW-1:0]                grant_q;
  logic [IW-1:0]                rr_ptr_q;
  logic [IW-1:0]                next_ptr;
  logic [WD_W-1:0]              wd_q;
  logic [TXARB_CNT_W-1:0]       pkt_q   [NUM_CHAN];
  logic [TXARB_ABORT_CNT_W-1:0] abort_q [NUM_CHAN];
  logic [DATA_WIDTH-1:0]        ch_data [NUM_CHAN];
  logic [KEEP_W-1:0]            ch_keep [NUM_CHAN];

  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          sel_valid;
  logic          sel_last;

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_ch
    assign ch_data[g] = in_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign ch_keep[g] = in_tkeep[g*KEEP_W +: KEEP_W];
    assign pkt_cnt[g*TXARB_CNT_W +: TXARB_CNT_W]               = pkt_q[g];
    assign abort_cnt[g*TXARB_ABORT_CNT_W +: TXARB_ABORT_CNT_W] = abort_q[g];
  end

  udp_oe_rr_pick #(
    .NUM_CHAN (NUM_CHAN),
    .IW       (IW)
  ) u_pick (
    .req     (in_tvalid & chan_en),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign sel_valid = in_tvalid[grant_q];
  assign sel_last  = in_tlast[grant_q];
  assign next_ptr  = (grant_q == IW'(NUM_CHAN - 1)) ? '0 : grant_q + IW'(1);
  assign cur_grant = grant_q;
  assign busy      = (state_q != IDLE);

  // State, grant, watchdog and per-channel counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
        pkt_q[i]   <= '0;
        abort_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            wd_q    <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (sel_valid && out_tready) begin
            wd_q <= '0;
            if (sel_last) begin
              pkt_q[grant_q] <= pkt_q[grant_q] + TXARB_CNT_W'(1);
              rr_ptr_q       <= next_ptr;
              state_q        <= IDLE;
            end
          end else if (!sel_valid && WD_EN) begin
            // Only source-side silence counts; MAC backpressure keeps valid high.
            if (wd_q == WD_LAST) begin
              wd_q    <= '0;
              state_q <= ABORT;
            end else begin
              wd_q <= wd_q + WD_W'(1);
            end
          end
        end
        ABORT: begin
          if (out_tready) begin
            if (abort_q[grant_q] != '1) abort_q[grant_q] <= abort_q[grant_q] + TXARB_ABORT_CNT_W'(1);
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!chan_en[grant_q] || (sel_valid && sel_last)) begin
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stream steering: pass-through in XFER, synthetic abort beat, silent drain.
  always_comb begin
    in_tready  = '0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tuser  = 1'b0;
    unique case (state_q)
      XFER: begin
        out_tvalid         = sel_valid;
        out_tdata          = ch_data[grant_q];
        out_tkeep          = ch_keep[grant_q];
        out_tlast          = sel_last;
        in_tready[grant_q] = out_tready;
      end
      ABORT: begin
        out_tvalid = 1'b1;
        out_tkeep  = '1;
        out_tlast  = 1'b1;
        out_tuser  = 1'b1;
      end
      DRAIN:   in_tready[grant_q] = 1'b1;
      default: ;
    endcase
  end

endmodule
